// File: rtl/scoreboard_hazard_unit_pkg.sv
// Shared types and defaults for the decode/issue hazard unit.
// Functional units, stall causes, and pipeline depth defaults.
package scoreboard_hazard_unit_pkg;

  localparam int DEF_MUL_LATENCY = 5;
  localparam int DEF_ROB_DEPTH   = 16;

  typedef enum logic [1:0] {
    UNIT_ALU  = 2'd0,
    UNIT_LOAD = 2'd1,
    UNIT_MUL  = 2'd2
  } unit_e;

  typedef enum logic [1:0] {
    CAUSE_NONE = 2'd0,
    CAUSE_ROB  = 2'd1,
    CAUSE_RAW  = 2'd2,
    CAUSE_WB   = 2'd3
  } stall_cause_e;

  // Only long-latency results need a scoreboard entry; ALU results are forwarded.
  function automatic logic unit_is_tracked(unit_e u);
    return (u == UNIT_LOAD) || (u == UNIT_MUL);
  endfunction

endpackage

// File: rtl/scoreboard_hazard_unit_if.sv
// Decode, write-back, MEM/ALU status and hazard-unit response bundle.
// master drives decode/pipeline status, slave is the hazard unit.
interface scoreboard_hazard_unit_if #(
  parameter int REGISTER_WIDTH = 5,
  parameter int NUM_REGS       = 32,
  parameter int CNT_WIDTH      = 32
) ();
  import scoreboard_hazard_unit_pkg::*;

  logic                      dec_valid;
  unit_e                     dec_unit;
  logic [REGISTER_WIDTH-1:0] dec_rs1;
  logic                      dec_rs1_needed;
  logic [REGISTER_WIDTH-1:0] dec_rs2;
  logic                      dec_rs2_needed;
  logic [REGISTER_WIDTH-1:0] dec_rd;
  logic                      dec_rd_wr_en;
  logic                      wb_valid;
  logic [REGISTER_WIDTH-1:0] wb_reg;
  logic                      mem_busy;
  logic                      mem_done;
  logic                      alu_branch_taken;
  logic                      alu_is_jump;
  logic                      rob_commit;

  logic                      issue;
  logic                      stall_decode;
  logic                      stall_fetch;
  logic                      stall_mem;
  logic                      flush;
  logic                      alu_bubble;
  logic                      ex_bubble;
  logic                      rob_full;
  logic [NUM_REGS-1:0]       pending;
  logic [CNT_WIDTH-1:0]      stall_cnt_rob;
  logic [CNT_WIDTH-1:0]      stall_cnt_raw;
  logic [CNT_WIDTH-1:0]      stall_cnt_wb;

  modport master (
    output dec_valid, dec_unit, dec_rs1, dec_rs1_needed, dec_rs2, dec_rs2_needed,
           dec_rd, dec_rd_wr_en, wb_valid, wb_reg, mem_busy, mem_done,
           alu_branch_taken, alu_is_jump, rob_commit,
    input  issue, stall_decode, stall_fetch, stall_mem, flush, alu_bubble, ex_bubble,
           rob_full, pending, stall_cnt_rob, stall_cnt_raw, stall_cnt_wb
  );

  modport slave (
    input  dec_valid, dec_unit, dec_rs1, dec_rs1_needed, dec_rs2, dec_rs2_needed,
           dec_rd, dec_rd_wr_en, wb_valid, wb_reg, mem_busy, mem_done,
           alu_branch_taken, alu_is_jump, rob_commit,
    output issue, stall_decode, stall_fetch, stall_mem, flush, alu_bubble, ex_bubble,
           rob_full, pending, stall_cnt_rob, stall_cnt_raw, stall_cnt_wb
  );

endinterface

// File: rtl/scoreboard_hazard_unit_sat_counter.sv
// Saturating event counter with enable; cleared asynchronously by rst_ni.
// Latency 1 cycle from enable to count; holds at all-ones, never wraps.
module hazard_sat_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 en,
  output logic [CNT_WIDTH-1:0] cnt
);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/scoreboard_hazard_unit.sv
// Decode/issue hazard unit: scoreboard, WB-slot reservation, ROB credits, stall counters.
// Issue decision is combinational in the decode cycle; stalls hold decode/fetch, the MUL pipe never stalls.
module scoreboard_hazard_unit
  import scoreboard_hazard_unit_pkg::*;
#(
  parameter int REGISTER_WIDTH = 5,
  parameter int NUM_REGS       = 2**REGISTER_WIDTH,
  parameter int MUL_LATENCY    = DEF_MUL_LATENCY,
  parameter int ROB_DEPTH      = DEF_ROB_DEPTH,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  scoreboard_hazard_unit_if.slave bus
);

  localparam int ROB_W = $clog2(ROB_DEPTH + 1);

  logic [NUM_REGS-1:0]  pending_q, pending_d;
  logic [MUL_LATENCY:0] res_q, res_d;
  logic [ROB_W-1:0]     rob_cnt_q, rob_cnt_d;

  logic         flush, rs1_haz, rs2_haz, raw, wb_conf, rob_full;
  logic         stall, issue, set_pend, commit_ok;
  stall_cause_e cause;

  always_comb begin
    flush    = bus.alu_branch_taken | bus.alu_is_jump;
    rs1_haz  = bus.dec_rs1_needed && (bus.dec_rs1 != '0) && pending_q[bus.dec_rs1];
    rs2_haz  = bus.dec_rs2_needed && (bus.dec_rs2 != '0) && pending_q[bus.dec_rs2];
    raw      = bus.dec_valid && (rs1_haz || rs2_haz);
    // res[1] means the slot one cycle after an ALU issue is already promised to a MUL.
    wb_conf  = bus.dec_valid && (bus.dec_unit == UNIT_ALU) && res_q[1];
    rob_full = (rob_cnt_q == ROB_W'(ROB_DEPTH));
    stall    = bus.dec_valid && !flush && (rob_full || raw || wb_conf);
    issue    = bus.dec_valid && !flush && !stall;
  end

  always_comb begin
    cause = CAUSE_NONE;
    if (stall) begin
      if (rob_full)  cause = CAUSE_ROB;
      else if (raw)  cause = CAUSE_RAW;
      else           cause = CAUSE_WB;
    end
  end

  always_comb begin
    pending_d = pending_q;
    if (bus.wb_valid) pending_d[bus.wb_reg] = 1'b0;
    set_pend = issue && bus.dec_rd_wr_en && (bus.dec_rd != '0) && unit_is_tracked(bus.dec_unit);
    if (set_pend) pending_d[bus.dec_rd] = 1'b1;
    pending_d[0] = 1'b0;

    res_d = res_q >> 1;
    if (issue && (bus.dec_unit == UNIT_ALU)) res_d[0] = 1'b1;
    if (issue && (bus.dec_unit == UNIT_MUL)) res_d[MUL_LATENCY-1] = 1'b1;

    commit_ok = bus.rob_commit && (rob_cnt_q != '0);
    rob_cnt_d = rob_cnt_q;
    if (issue && !commit_ok)      rob_cnt_d = rob_cnt_q + ROB_W'(1);
    else if (!issue && commit_ok) rob_cnt_d = rob_cnt_q - ROB_W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= '0;
      res_q     <= '0;
      rob_cnt_q <= '0;
    end else begin
      pending_q <= pending_d;
      res_q     <= res_d;
      rob_cnt_q <= rob_cnt_d;
    end
  end

  hazard_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_rob (
    .clk_i (clk_i), .rst_ni (rst_ni), .en (cause == CAUSE_ROB), .cnt (bus.stall_cnt_rob)
  );
  hazard_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_raw (
    .clk_i (clk_i), .rst_ni (rst_ni), .en (cause == CAUSE_RAW), .cnt (bus.stall_cnt_raw)
  );
  hazard_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt_wb (
    .clk_i (clk_i), .rst_ni (rst_ni), .en (cause == CAUSE_WB), .cnt (bus.stall_cnt_wb)
  );

  // Combinational outputs are forced quiet while reset is held; MEM hold still follows mem_busy.
  assign bus.flush        = rst_ni & flush;
  assign bus.stall_decode = rst_ni & stall;
  assign bus.stall_fetch  = rst_ni & stall;
  assign bus.issue        = rst_ni & issue;
  assign bus.alu_bubble   = rst_ni & (!issue || (bus.dec_unit == UNIT_MUL));
  assign bus.ex_bubble    = rst_ni & (!issue || (bus.dec_unit != UNIT_MUL));
  assign bus.stall_mem    = bus.mem_busy | (rst_ni & bus.mem_done & res_q[0]);
  assign bus.rob_full     = rob_full;
  assign bus.pending      = pending_q;

`ifndef SYNTHESIS
  commit_underflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(bus.rob_commit && (rob_cnt_q == '0)));
`endif

endmodule
